// File: rtl/grads_window3x3.sv
// 3x3 sliding-window generator: two line memories plus three 24-bit row shift
// registers, emitting interior windows through a single AXI4-Stream output register.
module grads_window3x3 #(
    parameter int LINE_WIDTH = 640,
    parameter int ADDR_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [23:0] line_buff_0_tdata,
    output logic [23:0] line_buff_1_tdata,
    output logic [23:0] line_buff_2_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);
    localparam logic [10:0]       ROW_MAX  = 11'd2047;
    localparam int                DEPTH    = 2 ** ADDR_W;

    // mem0 holds row r-1, mem1 holds row r-2 at each column.
    logic [7:0] mem0 [0:DEPTH-1];
    logic [7:0] mem1 [0:DEPTH-1];

    logic [ADDR_W-1:0] col_q, col_d;
    logic [10:0]       row_q, row_d;
    logic [23:0]       win0_q, win1_q, win2_q;
    logic [23:0]       win0_d, win1_d, win2_d;
    logic [23:0]       out0_q, out1_q, out2_q;
    logic              m_valid_q, m_valid_d;
    logic              m_user_q, m_last_q;

    logic              s_ready;
    logic              acc;
    logic [ADDR_W-1:0] eff_col;
    logic [10:0]       eff_row;
    logic [7:0]        rd0, rd1;
    logic              end_of_line;
    logic              load;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        s_ready     = ~m_valid_q | m_axis_tready;
        acc         = s_axis_tvalid & s_ready;
        // A start-of-frame pixel is placed at (0,0) whatever the counters say.
        eff_col     = s_axis_tuser ? '0 : col_q;
        eff_row     = s_axis_tuser ? '0 : row_q;
        rd0         = mem0[eff_col];
        rd1         = mem1[eff_col];
        end_of_line = s_axis_tlast | (eff_col == LAST_COL);
        win0_d      = {rd1, win0_q[23:8]};
        win1_d      = {rd0, win1_q[23:8]};
        win2_d      = {s_axis_tdata, win2_q[23:8]};
        load        = acc & (eff_row >= 11'd2) & (eff_col >= ADDR_W'(2));
        m_valid_d   = load | (m_valid_q & ~m_axis_tready);

        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (end_of_line) begin
                col_d = '0;
                row_d = (eff_row == ROW_MAX) ? eff_row : eff_row + 11'd1;
            end else begin
                col_d = eff_col + ADDR_W'(1);
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            win0_q    <= '0;
            win1_q    <= '0;
            win2_q    <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            m_valid_q <= 1'b0;
            m_user_q  <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            if (acc) begin
                win0_q <= win0_d;
                win1_q <= win1_d;
                win2_q <= win2_d;
            end
            if (load) begin
                out0_q   <= win0_d;
                out1_q   <= win1_d;
                out2_q   <= win2_d;
                m_user_q <= (eff_row == 11'd2) && (eff_col == ADDR_W'(2));
                m_last_q <= end_of_line;
            end
        end
    end

    // NOTE: the line memories have no reset; stale rows are masked by the
    // r>=2 rule. Non-blocking writes give read-before-write against rd0/rd1.
    always_ff @(posedge clk) begin
        if (acc && !rst) begin
            mem1[eff_col] <= rd0;
            mem0[eff_col] <= s_axis_tdata;
        end
    end

    assign s_axis_tready     = s_ready;
    assign line_buff_0_tdata = out0_q;
    assign line_buff_1_tdata = out1_q;
    assign line_buff_2_tdata = out2_q;
    assign m_axis_tvalid     = m_valid_q;
    assign m_axis_tuser      = m_user_q;
    assign m_axis_tlast      = m_last_q;

endmodule

// File: tb/tb_grads_window3x3.sv
// Bench for grads_window3x3: directed and random frames on W=5 and W=8 instances,
// compared against a frame-array window model; stalls and backpressure are watched continuously.
module tb_grads_window3x3;

    typedef struct packed {
        logic [23:0] l0;
        logic [23:0] l1;
        logic [23:0] l2;
        logic        user;
        logic        last;
    } win_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tuser, s_tlast;
    logic       m_tready;
    logic       sel;
    int         rmode;
    int         phase;
    bit         gaps;

    logic        rdy5, v5, u5, t5, rdy8, v8, u8, t8;
    logic [23:0] a5, b5, c5, a8, b8, c8;

    logic        o_srdy, o_valid, o_user, o_last;
    logic [23:0] o_l0, o_l1, o_l2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pix [0:7][0:7];
    int         lens [0:7];
    bit         lastflag [0:7];
    int         fh;

    win_t exp_q[$];
    win_t obs_q[$];

    always #5 clk = ~clk;

    grads_window3x3 #(.LINE_WIDTH(5), .ADDR_W(3)) u_dut5 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy5),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .line_buff_0_tdata(a5), .line_buff_1_tdata(b5), .line_buff_2_tdata(c5),
        .m_axis_tvalid(v5), .m_axis_tready(m_tready),
        .m_axis_tuser(u5), .m_axis_tlast(t5)
    );

    grads_window3x3 #(.LINE_WIDTH(8), .ADDR_W(3)) u_dut8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy8),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .line_buff_0_tdata(a8), .line_buff_1_tdata(b8), .line_buff_2_tdata(c8),
        .m_axis_tvalid(v8), .m_axis_tready(m_tready),
        .m_axis_tuser(u8), .m_axis_tlast(t8)
    );

    assign o_srdy  = sel ? rdy8 : rdy5;
    assign o_valid = sel ? v8 : v5;
    assign o_user  = sel ? u8 : u5;
    assign o_last  = sel ? t8 : t5;
    assign o_l0    = sel ? a8 : a5;
    assign o_l1    = sel ? b8 : b5;
    assign o_l2    = sel ? c8 : c5;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Downstream ready patterns: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rmode)
            1: begin
                m_tready = (phase == 0) || (phase == 3);
                phase    = (phase + 1) % 4;
            end
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b1;
        endcase
    end

    // Output monitor: collects transfers, checks holding during stalls and input backpressure.
    logic  prev_stall = 1'b0;
    win_t  held;
    always @(negedge clk) begin
        win_t cur;
        cur = {o_l0, o_l1, o_l2, o_user, o_last};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 80'(o_valid), 80'(1'b1));
                check("hold_data", 80'(cur), 80'(held));
            end
            if (o_valid && !m_tready)
                check("sready_low", 80'(o_srdy), 80'(1'b0));
            if (o_valid && m_tready)
                obs_q.push_back(cur);
            prev_stall = o_valid && !m_tready;
            held       = cur;
        end
    end

    task automatic send_px(input logic [7:0] d, input logic u, input logic l);
        int waited = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!o_srdy && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!o_srdy) check("accept_timeout", 80'(o_srdy), 80'(1'b1));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build_ramp(input int w, input int h);
        fh = h;
        for (int r = 0; r < h; r++) begin
            lens[r]     = w;
            lastflag[r] = 1'b1;
            for (int c = 0; c < w; c++) pix[r][c] = 8'(10 * r + c);
        end
    endtask

    task automatic send_frame();
        for (int r = 0; r < fh; r++)
            for (int c = 0; c < lens[r]; c++)
                send_px(pix[r][c], (r == 0 && c == 0), (c == lens[r] - 1) && lastflag[r]);
    endtask

    // Reference: every interior (r,c) of the frame array yields one window,
    // tuser at (2,2), tlast on the last column of the line.
    task automatic build_expect();
        win_t w;
        exp_q.delete();
        for (int r = 2; r < fh; r++)
            for (int c = 2; c < lens[r]; c++) begin
                w.l0   = {pix[r-2][c], pix[r-2][c-1], pix[r-2][c-2]};
                w.l1   = {pix[r-1][c], pix[r-1][c-1], pix[r-1][c-2]};
                w.l2   = {pix[r][c],   pix[r][c-1],   pix[r][c-2]};
                w.user = (r == 2 && c == 2);
                w.last = (c == lens[r] - 1);
                exp_q.push_back(w);
            end
    endtask

    task automatic compare_frame(input string tag);
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        check({tag, "_count"}, 80'(obs_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_win"}, 80'(obs_q[i]), 80'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        sel = 1'b0; rmode = 0; phase = 0; gaps = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 80'(o_valid), 80'(1'b0));
        check("rst_sideband", 80'({o_user, o_last}), 80'(2'b00));
        check("rst_data", 80'({o_l0, o_l1, o_l2}), 80'(0));
        check("rst_sready", 80'(o_srdy), 80'(1'b1));

        // Ramp 5x5, ready held high.
        build_ramp(5, 5);
        build_expect();
        send_frame();
        compare_frame("ramp");
        check("ramp_n9", 80'(obs_q.size()), 80'(9));
        if (obs_q.size() > 0) begin
            check("ramp_first_l0", 80'(obs_q[0].l0), 80'(24'h020100));
            check("ramp_first_l1", 80'(obs_q[0].l1), 80'(24'h0C0B0A));
            check("ramp_first_l2", 80'(obs_q[0].l2), 80'(24'h161514));
            check("ramp_first_user", 80'(obs_q[0].user), 80'(1'b1));
        end
        for (int i = 0; i < obs_q.size(); i++)
            check("ramp_tlast", 80'(obs_q[i].last), 80'(i % 3 == 2));
        obs_q.delete();

        // Same ramp, downstream ready toggling 1,0,0,1.
        rmode = 1;
        send_frame();
        compare_frame("ramp_stall");
        obs_q.delete();
        rmode = 0;

        // Constant frame on the W=8 instance.
        sel = 1'b1;
        fh  = 4;
        for (int r = 0; r < 4; r++) begin
            lens[r] = 8; lastflag[r] = 1'b1;
            for (int c = 0; c < 8; c++) pix[r][c] = 8'h80;
        end
        build_expect();
        send_frame();
        compare_frame("const");
        check("const_n12", 80'(obs_q.size()), 80'(12));
        if (obs_q.size() > 0)
            check("const_word", 80'(obs_q[0].l1), 80'(24'h808080));
        obs_q.delete();
        sel = 1'b0;

        // Reset after 13 pixels of a ramp, then a fresh frame.
        build_ramp(5, 5);
        for (int k = 0; k < 13; k++)
            send_px(pix[k / 5][k % 5], (k == 0), (k % 5 == 4));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 80'(o_valid), 80'(1'b0));
        check("midrst_data", 80'({o_l0, o_l1, o_l2, o_user, o_last}), 80'(0));
        obs_q.delete();
        build_expect();
        send_frame();
        compare_frame("after_rst");
        obs_q.delete();

        // tuser restart after 7 pixels.
        for (int k = 0; k < 7; k++)
            send_px(pix[k / 5][k % 5], (k == 0), (k % 5 == 4));
        send_frame();
        compare_frame("restart");
        obs_q.delete();

        // Early tlast at c=3 on every line.
        build_ramp(4, 5);
        build_expect();
        send_frame();
        compare_frame("early");
        check("early_n6", 80'(obs_q.size()), 80'(6));
        for (int i = 0; i < obs_q.size(); i++)
            check("early_tlast", 80'(obs_q[i].last), 80'(i % 2 == 1));
        obs_q.delete();

        // Random frames, random stalls, input gaps, sometimes no tlast at full width.
        rmode = 2;
        gaps  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int w, len;
            sel = 1'(k % 2);
            w   = sel ? 8 : 5;
            fh  = $urandom_range(3, 6);
            len = ($urandom_range(0, 1) == 1) ? w : $urandom_range(3, w);
            for (int r = 0; r < fh; r++) begin
                lens[r]     = len;
                lastflag[r] = (len < w) ? 1'b1 : 1'($urandom_range(0, 1));
                for (int c = 0; c < len; c++) pix[r][c] = 8'($urandom_range(0, 255));
            end
            build_expect();
            send_frame();
            compare_frame("random");
            obs_q.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grads_window3x3.md
Name: grads_window3x3

Overview:
- Upstream neighbour of the 3x3 gradient stage.
- Accepts an 8-bit grey AXI4-Stream pixel stream (raster order, tuser = start of frame, tlast = end of line).
- Keeps two previous lines in line memories and emits a registered 3x3 window as three 24-bit row words (line_buff_0/1/2_tdata) that feed the gradient stage directly.
- Interior windows only: a WxH frame yields (W-2)x(H-2) windows.

Parameters:
- LINE_WIDTH, 640, pixels per line (W); 3..2048.
- ADDR_W, 11, line-memory address width; 2**ADDR_W >= LINE_WIDTH.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- s_axis_tdata  in  8  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tuser  in  1  first pixel of frame
- s_axis_tlast  in  1  last pixel of line
- line_buff_0_tdata  out  24  window row r-2
- line_buff_1_tdata  out  24  window row r-1 (centre row)
- line_buff_2_tdata  out  24  window row r
- m_axis_tvalid  out  1  window valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  first window of frame
- m_axis_tlast  out  1  last window of line

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - All outputs 0 except s_axis_tready, which is 1 while rst is low.
  - col=0, row=0, window shift registers 0.
  - Line memories are not cleared.
- Accept condition: acc = s_axis_tvalid & s_axis_tready.
- Ready rule: s_axis_tready = ~m_axis_tvalid | m_axis_tready. Single output register, no bubbles under continuous flow.
- Byte layout in each row word:
  - [7:0] = column c-2
  - [15:8] = column c-1 (centre)
  - [23:16] = column c (newest)
- Per accepted pixel p at (row r, col c):
  - The new column is {mem1[c], mem0[c], p}, giving rows r-2, r-1, r.
  - Each row word shifts right by 8 bits, and the new byte enters at [23:16].
  - Memory update in the same cycle: mem1[c] <= mem0[c], mem0[c] <= p. Read returns the old data (read-before-write, asynchronous read).
- Counters:
  - On acc, c increments.
  - c resets to 0 and r increments when s_axis_tlast=1 or when c == LINE_WIDTH-1. A missing tlast wraps at LINE_WIDTH; an early tlast shortens the line.
  - r saturates at 2047.
- Start of frame: acc with s_axis_tuser=1 forces this pixel to (0,0), regardless of the current counters. A mid-frame tuser therefore restarts the frame, and stale memory contents are masked by the r>=2 rule.
- Output:
  - On acc with r>=2 and c>=2, the output register loads the shifted window and m_axis_tvalid becomes 1 the next cycle. This is 1-cycle latency, centred on pixel (r-1, c-1).
  - m_axis_tuser = 1 when (r,c) = (2,2).
  - m_axis_tlast = 1 when the pixel that produced the window carried tlast, or c == LINE_WIDTH-1.
- Hold and clear:
  - m_axis_tvalid with m_axis_tready=0 holds data and sideband stable.
  - On m_axis_tready=1 with no new window loading, m_axis_tvalid clears.
  - Load and drain in the same cycle is allowed and keeps tvalid high.
- Reset mid-operation: the next cycle matches the reset values. A window in flight is dropped, and the next frame must begin with tuser.

Test Plan:
- Ramp frame W=H=5 (LINE_WIDTH=5), pixel = 10*r+c, tready held 1:
  - Exactly 9 windows.
  - First window: line_buff_0=0x020100, line_buff_1=0x0C0B0A, line_buff_2=0x161514, with tuser=1.
  - Every third window has tlast=1.
- Same frame with m_axis_tready toggling 1,0,0,1:
  - Window sequence is identical to the previous test.
  - Data is stable while stalled.
  - s_axis_tready=0 whenever m_axis_tvalid=1 and m_axis_tready=0.
- Constant 0x80 frame, W=8, H=4: 12 windows, all three words = 0x808080.
- Reset mid-frame:
  - Assert rst for 1 cycle after 13 pixels of a 5x5 ramp.
  - m_axis_tvalid=0 the next cycle.
  - A fresh tuser frame then reproduces the ramp results of the first test.
- tuser after 7 pixels of a frame:
  - No window is emitted until the restarted frame reaches (2,2).
  - First window equals the first-test window for the same ramp data.
- Early tlast at c=3 on every line, LINE_WIDTH=5:
  - 2 windows per line from row 2 onward.
  - Second window of each line has tlast=1.
